multi_blinker: RTL and testbench

Parametrised N-channel successor to the single-channel blinker. Each channel drives one output bit from one switch input. A global mode selects one of four behaviours: legacy level toggle, edge toggle, armed periodic blink with a programmable half-period, or hold. It sits between debounced user switches and LED/indicator outputs on the lab board.

---
 rtl/multi_blinker.sv | 88 ++++++++
 tb/tb_multi_blinker.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/multi_blinker.sv
`default_nettype none
// ============================================================================
//  Module   : multi_blinker
//  Purpose  : N-channel switch-to-indicator driver. A global mode selects
//             level toggle, edge toggle, armed periodic blink with a shared
//             programmable half-period, or hold.
//  Revision : 1.0  initial release
// ============================================================================
module multi_blinker #(
   parameter int N         = 4,
   parameter int DIV_WIDTH = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [N-1:0]         switch,
   input  logic [1:0]           mode,
   input  logic [DIV_WIDTH-1:0] div,
   output logic [N-1:0]         out,
   output logic [N-1:0]         armed
);

   localparam logic [1:0] c_MODE_LEVEL = 2'b00;
   localparam logic [1:0] c_MODE_EDGE  = 2'b01;
   localparam logic [1:0] c_MODE_BLINK = 2'b10;

   localparam logic [DIV_WIDTH-1:0] c_CNT_ONE = {{(DIV_WIDTH-1){1'b0}}, 1'b1};

   for (genvar gi = 0; gi < N; gi++) begin : g_ch
      logic                 r_out;
      logic                 r_armed;
      logic                 r_prev;
      logic [DIV_WIDTH-1:0] r_cnt;
      logic                 w_rise;

      // Rising edge relative to last cycle's sample; prev is 0 after reset,
      // so a switch already high on the first cycle counts as a rise.
      assign w_rise = switch[gi] & ~r_prev;

      // Per-channel state update. armed/cnt default to 0 so that any
      // non-BLINK mode (and a disarmed BLINK channel) keeps them cleared;
      // out is only written where a mode explicitly changes it.
      always_ff @(posedge clk) begin
         if (!rst) begin
            r_out   <= 1'b0;
            r_armed <= 1'b0;
            r_prev  <= 1'b0;
            r_cnt   <= '0;
         end else begin
            r_prev  <= switch[gi];
            r_armed <= 1'b0;
            r_cnt   <= '0;
            case (mode)
               c_MODE_LEVEL: begin
                  if (switch[gi]) r_out <= ~r_out;
               end
               c_MODE_EDGE: begin
                  if (w_rise) r_out <= ~r_out;
               end
               c_MODE_BLINK: begin
                  if (w_rise) begin
                     // Rise flips arming; arming lights the output, disarming
                     // darkens it. Wins over a same-cycle terminal count.
                     r_armed <= ~r_armed;
                     r_out   <= ~r_armed;
                  end else if (r_armed) begin
                     r_armed <= 1'b1;
                     // >= so a live shrink of div below cnt toggles next
                     // cycle instead of letting cnt run on and wrap.
                     if (r_cnt >= div) begin
                        r_out <= ~r_out;
                     end else begin
                        r_cnt <= r_cnt + c_CNT_ONE;
                     end
                  end
               end
               default: begin
                  // HOLD: out frozen, armed/cnt cleared by defaults.
               end
            endcase
         end
      end

      assign out[gi]   = r_out;
      assign armed[gi] = r_armed;
   end : g_ch

endmodule : multi_blinker
`default_nettype wire

// File: tb/tb_multi_blinker.sv
`default_nettype none
// ============================================================================
//  Module   : tb_multi_blinker
//  Purpose  : Scoreboard bench for multi_blinker. Stimulus pushes expected
//             out/armed from a timestamp-based reference model; a monitor
//             pops and compares after every rising edge.
//  Revision : 1.0  initial release
// ============================================================================
module tb_multi_blinker;

   localparam int N  = 4;
   localparam int DW = 8;

   logic          clk;
   logic          rst;
   logic [N-1:0]  switch;
   logic [1:0]    mode;
   logic [DW-1:0] div;
   logic [N-1:0]  out;
   logic [N-1:0]  armed;

   multi_blinker #(.N(N), .DIV_WIDTH(DW)) dut (
      .clk    (clk),
      .rst    (rst),
      .switch (switch),
      .mode   (mode),
      .div    (div),
      .out    (out),
      .armed  (armed)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [N-1:0] o;
      logic [N-1:0] a;
      string        tag;
   } exp_t;

   exp_t  sbq[$];
   int    checks = 0;
   int    errors = 0;
   string phase  = "init";

   // Reference model: blink timing kept as "edge index of last arm/toggle";
   // a toggle is due when more than div edges have elapsed since then.
   bit m_out   [N];
   bit m_armed [N];
   bit m_prev  [N];
   int m_last  [N];
   int t = 0;

   function automatic void model_edge(input logic r, input logic [1:0] md,
                                      input logic [N-1:0] sw, input int dv);
      t++;
      for (int i = 0; i < N; i++) begin
         if (!r) begin
            m_out[i] = 0; m_armed[i] = 0; m_prev[i] = 0; m_last[i] = t;
         end else begin
            bit rise;
            rise = sw[i] && !m_prev[i];
            case (md)
               2'd0: begin if (sw[i]) m_out[i] = !m_out[i]; m_armed[i] = 0; end
               2'd1: begin if (rise) m_out[i] = !m_out[i]; m_armed[i] = 0; end
               2'd2: begin
                  if (rise) begin
                     if (m_armed[i]) begin m_armed[i] = 0; m_out[i] = 0; end
                     else begin m_armed[i] = 1; m_out[i] = 1; m_last[i] = t; end
                  end else if (m_armed[i] && (t - m_last[i] > dv)) begin
                     m_out[i] = !m_out[i];
                     m_last[i] = t;
                  end
               end
               default: m_armed[i] = 0;
            endcase
            m_prev[i] = sw[i];
         end
      end
   endfunction

   task automatic step(input logic r, input logic [1:0] md,
                       input logic [N-1:0] sw, input int dv);
      exp_t e;
      @(negedge clk);
      rst = r; mode = md; switch = sw; div = DW'(dv);
      model_edge(r, md, sw, dv);
      for (int i = 0; i < N; i++) begin
         e.o[i] = m_out[i];
         e.a[i] = m_armed[i];
      end
      e.tag = phase;
      sbq.push_back(e);
   endtask

   task automatic idle(input int n, input logic [1:0] md, input int dv);
      for (int k = 0; k < n; k++) step(1'b1, md, '0, dv);
   endtask

   // Monitor: one registered result per edge, compared away from the edge.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (sbq.size() > 0) begin
            e = sbq.pop_front();
            checks++;
            if (out !== e.o || armed !== e.a) begin
               errors++;
               $display("FAIL %s t=%0t out=%b armed=%b expected out=%b armed=%b",
                        e.tag, $time, out, armed, e.o, e.a);
            end
         end
      end
   end

   initial begin
      logic [1:0]   rmd;
      logic [N-1:0] rsw;
      int           rdv;
      rst = 1'b0; mode = 2'b00; switch = '0; div = '0;

      phase = "reset";
      step(1'b0, 2'b00, '0, 0);
      step(1'b0, 2'b00, '0, 0);

      phase = "level_pulse";
      step(1'b1, 2'b00, 4'b0001, 0);
      idle(2, 2'b00, 0);
      step(1'b1, 2'b00, 4'b0001, 0);
      idle(2, 2'b00, 0);
      phase = "level_hold";
      for (int k = 0; k < 5; k++) step(1'b1, 2'b00, 4'b0010, 0);
      idle(2, 2'b00, 0);

      phase = "edge";
      for (int k = 0; k < 5; k++) step(1'b1, 2'b01, 4'b0100, 0);
      idle(1, 2'b01, 0);
      step(1'b1, 2'b01, 4'b0100, 0);
      idle(2, 2'b01, 0);

      phase = "blink_div3";
      step(1'b1, 2'b10, 4'b0001, 3);
      idle(14, 2'b10, 3);
      step(1'b1, 2'b10, 4'b0001, 3);
      idle(3, 2'b10, 3);

      phase = "blink_div0";
      step(1'b1, 2'b10, 4'b0001, 0);
      idle(6, 2'b10, 0);
      step(1'b1, 2'b10, 4'b0001, 0);
      idle(2, 2'b10, 0);

      phase = "div_shrink";
      step(1'b1, 2'b10, 4'b0001, 200);
      idle(150, 2'b10, 200);
      idle(25, 2'b10, 10);
      step(1'b1, 2'b10, 4'b0001, 10);
      idle(2, 2'b10, 10);

      phase = "rise_at_terminal";
      step(1'b1, 2'b10, 4'b0001, 3);
      idle(3, 2'b10, 3);
      step(1'b1, 2'b10, 4'b0001, 3);
      idle(3, 2'b10, 3);

      phase = "mode_hold";
      step(1'b1, 2'b10, 4'b0001, 2);
      idle(4, 2'b10, 2);
      idle(3, 2'b11, 2);
      idle(6, 2'b10, 2);
      phase = "reset_mid_blink";
      step(1'b1, 2'b10, 4'b0011, 2);
      idle(4, 2'b10, 2);
      step(1'b0, 2'b10, 4'b0000, 2);
      idle(4, 2'b10, 2);

      phase = "independence";
      step(1'b1, 2'b10, 4'b1000, 1);
      idle(8, 2'b10, 1);
      for (int k = 0; k < 6; k++) step(1'b1, 2'b00, (k % 2 == 0) ? 4'b0001 : 4'b0000, 1);

      phase = "random";
      rmd = 2'b10; rsw = '0; rdv = 2;
      for (int k = 0; k < 3000; k++) begin
         if ($urandom_range(0, 39) == 0) rmd = 2'($urandom_range(0, 3));
         if ($urandom_range(0, 3) == 0)  rsw = N'($urandom);
         if ($urandom_range(0, 29) == 0)
            rdv = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 255))
                                              : int'($urandom_range(0, 6));
         step(($urandom_range(0, 199) != 0), rmd, rsw, rdv);
      end

      // Bounded drain of the scoreboard.
      repeat (3) @(posedge clk);
      #2;
      checks++;
      if (sbq.size() != 0) begin
         errors++;
         $display("FAIL drain pending=%0d expected pending=0", sbq.size());
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule : tb_multi_blinker
`default_nettype wire
